// File: rtl/pipes.sv
// Shared types for the instruction/data memory arbiter.
package pipes;

   typedef logic [31:0] u32;
   typedef logic [63:0] word_t;
   typedef logic [7:0]  u8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   // Address bit that selects the 32-bit half of a 64-bit memory word.
   localparam int unsigned WORD_SEL = 2;

   function automatic u32 fetch_word(input word_t rdata, input logic hi);
      return hi ? rdata[63:32] : rdata[31:0];
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Grant selection between fetch and data requesters (round-robin or data-first).
module rr_pick
   import pipes::*;
#(
   parameter bit FAIR = 1'b1
) (
   input  logic   i_ivalid,
   input  logic   i_dvalid,
   input  grant_t i_last,
   output grant_t o_grant_c
);

   always_comb begin
      o_grant_c = GRANT_I;
      if (i_ivalid && i_dvalid) begin
         if (FAIR) o_grant_c = (i_last == GRANT_D) ? GRANT_I : GRANT_D;
         else      o_grant_c = GRANT_D;
      end else if (i_dvalid) begin
         o_grant_c = GRANT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto a single memory port,
// one transaction outstanding at a time.
module mem_arbiter
   import pipes::*;
#(
   parameter bit FAIR = 1'b1
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  ireq_valid,
   input  u32    ireq_addr,
   output logic  iresp_ok,
   output u32    iresp_data,
   input  logic  dreq_valid,
   input  u32    dreq_addr,
   input  logic  dreq_we,
   input  word_t dreq_wdata,
   input  u8     dreq_strobe,
   output logic  dresp_ok,
   output word_t dresp_data,
   output logic  mem_valid,
   output u32    mem_addr,
   output logic  mem_we,
   output word_t mem_wdata,
   output u8     mem_strobe,
   input  logic  mem_ok,
   input  word_t mem_rdata
);

   arb_state_t r_state;
   grant_t     r_grant;
   grant_t     r_last;
   u32         r_addr;
   logic       r_we;
   word_t      r_wdata;
   u8          r_strobe;
   word_t      r_rdata;
   u32         r_iresp_data;
   logic       r_mem_valid;
   logic       r_iresp_ok;
   logic       r_dresp_ok;
   grant_t     w_pick;

   rr_pick #(.FAIR(FAIR)) u_pick (
      .i_ivalid  (ireq_valid),
      .i_dvalid  (dreq_valid),
      .i_last    (r_last),
      .o_grant_c (w_pick)
   );

   // Reset abandons any in-flight access; a late mem_ok is ignored in IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_grant      <= GRANT_I;
         r_last       <= GRANT_D;
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_wdata      <= '0;
         r_strobe     <= '0;
         r_rdata      <= '0;
         r_iresp_data <= '0;
         r_mem_valid  <= 1'b0;
         r_iresp_ok   <= 1'b0;
         r_dresp_ok   <= 1'b0;
      end else begin
         r_iresp_ok <= 1'b0;
         r_dresp_ok <= 1'b0;
         case (r_state)
            IDLE: begin
               if (ireq_valid || dreq_valid) begin
                  r_grant     <= w_pick;
                  r_last      <= w_pick;
                  r_mem_valid <= 1'b1;
                  r_state     <= BUSY;
                  if (w_pick == GRANT_D) begin
                     r_addr   <= dreq_addr;
                     r_we     <= dreq_we;
                     r_wdata  <= dreq_wdata;
                     r_strobe <= dreq_strobe;
                  end else begin
                     r_addr   <= ireq_addr;
                     r_we     <= 1'b0;
                     r_wdata  <= '0;
                     r_strobe <= 8'h00;
                  end
               end
            end
            BUSY: begin
               if (mem_ok) begin
                  r_rdata      <= mem_rdata;
                  r_iresp_data <= fetch_word(mem_rdata, r_addr[WORD_SEL]);
                  r_mem_valid  <= 1'b0;
                  r_iresp_ok   <= (r_grant == GRANT_I);
                  r_dresp_ok   <= (r_grant == GRANT_D);
                  r_state      <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign iresp_ok   = r_iresp_ok;
   assign iresp_data = r_iresp_data;
   assign dresp_ok   = r_dresp_ok;
   assign dresp_data = r_rdata;
   assign mem_valid  = r_mem_valid;
   assign mem_addr   = r_addr;
   assign mem_we     = r_we;
   assign mem_wdata  = r_wdata;
   assign mem_strobe = r_strobe;

endmodule
